// File: rtl/ibex_rf_banked.sv
// ibex_rf_banked
// Multi-context integer register file. Holds NumBanks complete register
// sets, serves the ID/WB read and write ports from the active bank, and runs
// a background engine that clones one bank into another one register per
// cycle while the core keeps executing.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   raddr_a_i / rdata_a_o    read port A (active bank, combinational)
//   raddr_b_i / rdata_b_o    read port B (active bank, combinational)
//   waddr_a_i, wdata_a_i,
//   we_a_i                   core write port (active bank)
//   switch_req_i, bank_sel_i request to make bank_sel_i the active bank
//   copy_req_i, copy_src_i,
//   copy_dst_i               request to copy every register src -> dst
//   active_bank_o            currently active bank
//   busy_o                   copy engine running
//   done_o                   one-cycle pulse: switch or copy completed
//   err_o                    one-cycle pulse: request rejected
module ibex_rf_banked #(
    parameter int unsigned            NumBanks    = 4,
    parameter bit                     RV32E       = 1'b0,
    parameter int unsigned            DataWidth   = 32,
    parameter logic [DataWidth-1:0]   WordZeroVal = '0,
    localparam int unsigned           BankW       = $clog2(NumBanks)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic [4:0]           raddr_a_i,
    output logic [DataWidth-1:0] rdata_a_o,
    input  logic [4:0]           raddr_b_i,
    output logic [DataWidth-1:0] rdata_b_o,

    input  logic [4:0]           waddr_a_i,
    input  logic [DataWidth-1:0] wdata_a_i,
    input  logic                 we_a_i,

    input  logic                 switch_req_i,
    input  logic [BankW-1:0]     bank_sel_i,
    input  logic                 copy_req_i,
    input  logic [BankW-1:0]     copy_src_i,
    input  logic [BankW-1:0]     copy_dst_i,

    output logic [BankW-1:0]     active_bank_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int unsigned     NumRegs = RV32E ? 16 : 32;
    localparam int unsigned     AddrW   = RV32E ? 4 : 5;
    localparam logic [AddrW-1:0] LastIdx = AddrW'(NumRegs - 1);

    typedef enum logic {
        IDLE,
        COPY
    } state_e;

    // x0 has no storage in any bank; indices start at 1.
    logic [DataWidth-1:0] regs_q [0:NumBanks-1][1:NumRegs-1];

    state_e           state_q, state_d;
    logic [AddrW-1:0] idx_q, idx_d;
    logic [BankW-1:0] src_q, src_d;
    logic [BankW-1:0] dst_q, dst_d;
    logic [BankW-1:0] active_bank_q, active_bank_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             copy_we;
    logic             switch_ok;
    logic             copy_ok;
    logic             reject;
    logic [DataWidth-1:0] copy_data;

    logic [AddrW-1:0] raddr_a;
    logic [AddrW-1:0] raddr_b;
    logic [AddrW-1:0] waddr;

    assign raddr_a = raddr_a_i[AddrW-1:0];
    assign raddr_b = raddr_b_i[AddrW-1:0];
    assign waddr   = waddr_a_i[AddrW-1:0];

    // In RV32E mode the top address bit is don't-care on every port.
    if (AddrW < 5) begin : g_unused_addr
        logic unused_addr_bits;
        assign unused_addr_bits = ^{raddr_a_i[4:AddrW], raddr_b_i[4:AddrW],
                                    waddr_a_i[4:AddrW]};
    end

    // Non-power-of-two bank counts leave encodable but nonexistent banks.
    function automatic logic bank_valid(input logic [BankW-1:0] b);
        return int'(b) < int'(NumBanks);
    endfunction

    function automatic logic [DataWidth-1:0] read_reg(input logic [BankW-1:0] bank,
                                                       input logic [AddrW-1:0] addr);
        if (addr == '0) begin
            return WordZeroVal;
        end
        return regs_q[bank][addr];
    endfunction

    // Ports A/B and the copy source are three independent read ports.
    assign rdata_a_o = read_reg(active_bank_q, raddr_a);
    assign rdata_b_o = read_reg(active_bank_q, raddr_b);
    assign copy_data = read_reg(src_q, idx_q);

    // Request arbitration: a switch and a copy in the same cycle are both
    // rejected rather than prioritised, and nothing is accepted mid-copy.
    assign switch_ok = (state_q == IDLE) && switch_req_i && !copy_req_i &&
                       bank_valid(bank_sel_i);
    assign copy_ok   = (state_q == IDLE) && copy_req_i && !switch_req_i &&
                       bank_valid(copy_src_i) && bank_valid(copy_dst_i);
    assign reject    = (switch_req_i || copy_req_i) && !switch_ok && !copy_ok;

    // Next-state logic: IDLE handles switches and copy starts, COPY walks
    // the index from 1 to the last register, one register per cycle.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        src_d         = src_q;
        dst_d         = dst_q;
        active_bank_d = active_bank_q;
        done_d        = 1'b0;
        err_d         = reject;
        copy_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (switch_ok) begin
                    active_bank_d = bank_sel_i;
                    done_d        = 1'b1;
                end else if (copy_ok) begin
                    state_d = COPY;
                    idx_d   = AddrW'(1);
                    src_d   = copy_src_i;
                    dst_d   = copy_dst_i;
                end
            end
            COPY: begin
                copy_we = 1'b1;
                if (idx_q == LastIdx) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + AddrW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state register; reset aborts any copy without pulsing
    // done_o or err_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            active_bank_q <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            active_bank_q <= active_bank_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    // Register storage. A core write to the same [dst][idx] the engine is
    // writing takes priority and the copied value is simply dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < int'(NumBanks); b++) begin
                for (int r = 1; r < int'(NumRegs); r++) begin
                    regs_q[b][r] <= WordZeroVal;
                end
            end
        end else begin
            for (int b = 0; b < int'(NumBanks); b++) begin
                for (int r = 1; r < int'(NumRegs); r++) begin
                    if (we_a_i && active_bank_q == BankW'(b) && waddr == AddrW'(r)) begin
                        regs_q[b][r] <= wdata_a_i;
                    end else if (copy_we && dst_q == BankW'(b) && idx_q == AddrW'(r)) begin
                        regs_q[b][r] <= copy_data;
                    end
                end
            end
        end
    end

    assign active_bank_o = active_bank_q;
    assign busy_o        = (state_q == COPY);
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule
